// File: rtl/hit_fifo_drain_if.sv
// Bundle for the summary-hit FIFO read side and the outgoing word stream.
// The master modport is the drain engine; the slave modport is the FIFO and
// downstream collection logic (or a testbench standing in for them).
interface hit_fifo_drain_if #(
    parameter int LENGTH_COUNTER = 8
);
    logic                      fifo_empty;
    logic                      read_HSP;
    logic [LENGTH_COUNTER-1:0] hit_add_inQ_UnGap;
    logic [LENGTH_COUNTER-1:0] hit_add_inS_UnGap;
    logic [LENGTH_COUNTER-1:0] hit_length_UnGap;
    logic [31:0]               out_data;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        input  fifo_empty,
        input  hit_add_inQ_UnGap,
        input  hit_add_inS_UnGap,
        input  hit_length_UnGap,
        input  out_ready,
        output read_HSP,
        output out_data,
        output out_valid
    );

    modport slave (
        output fifo_empty,
        output hit_add_inQ_UnGap,
        output hit_add_inS_UnGap,
        output hit_length_UnGap,
        output out_ready,
        input  read_HSP,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/hit_fifo_drain.sv
// hit_fifo_drain: reader side of a Blastn_Unit's summary hit FIFO.
// Pops one entry at a time, drops bubbles (raw length 0), packs each real
// hit as {unit_id, S addr, Q addr, raw length} and offers it on a
// valid/ready stream. At most one FIFO entry is in flight.
// Optional feature: define HIT_LEN_FILTER_EN to discard hits whose raw
// length is below MIN_LEN and count them in drop_count; without it every
// non-bubble hit is forwarded and drop_count stays 0.
module hit_fifo_drain #(
    parameter int LENGTH_COUNTER = 8,
    parameter int READ_LATENCY   = 1,
    parameter int CNT_W          = 16,
    parameter int MIN_LEN        = 4
) (
    input  logic                      array_clk,
    input  logic                      reset,
    input  logic [LENGTH_COUNTER-1:0] unit_id,
    hit_fifo_drain_if.master          bus,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          drop_count,
    output logic                      busy
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        CHECK,
        SEND
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    state_t                    state;
    state_t                    next_state;
    logic [1:0]                wait_cnt;
    logic                      wait_done;
    logic [LENGTH_COUNTER-1:0] cap_q;
    logic [LENGTH_COUNTER-1:0] cap_s;
    logic [LENGTH_COUNTER-1:0] cap_len;
    logic [31:0]               out_word;
    logic                      read_pop;
    logic                      send_valid;
    logic                      load_word;
    logic                      accept;
`ifdef HIT_LEN_FILTER_EN
    logic                      count_drop;
`endif

    assign wait_done = (wait_cnt == WAIT_LAST);
    assign accept    = send_valid & bus.out_ready;

    assign bus.read_HSP  = read_pop;
    assign bus.out_valid = send_valid;
    assign bus.out_data  = out_word;
    assign busy          = (state != IDLE);

    // State register; reset abandons whatever entry or word is in flight.
    always_ff @(posedge array_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobes; the pop strobe is a pure decode of POP so it
    // lasts exactly one cycle and can never coincide with a pending word.
    always_comb begin
        next_state = state;
        read_pop   = 1'b0;
        send_valid = 1'b0;
        load_word  = 1'b0;
`ifdef HIT_LEN_FILTER_EN
        count_drop = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    next_state = POP;
                end
            end
            POP: begin
                read_pop   = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (wait_done) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (cap_len == '0) begin
                    next_state = IDLE;
                end
`ifdef HIT_LEN_FILTER_EN
                else if (cap_len < LENGTH_COUNTER'(MIN_LEN)) begin
                    count_drop = 1'b1;
                    next_state = IDLE;
                end
`endif
                else begin
                    load_word  = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                send_valid = 1'b1;
                if (bus.out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Counts the FIFO read latency; restarts on every entry into WAIT.
    always_ff @(posedge array_clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 2'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Captures the FIFO data on the cycle the read latency has elapsed.
    always_ff @(posedge array_clk or posedge reset) begin
        if (reset) begin
            cap_q   <= '0;
            cap_s   <= '0;
            cap_len <= '0;
        end else if (state == WAIT && wait_done) begin
            cap_q   <= bus.hit_add_inQ_UnGap;
            cap_s   <= bus.hit_add_inS_UnGap;
            cap_len <= bus.hit_length_UnGap;
        end
    end

    // Output word is loaded once per forwarded hit and then held through SEND.
    always_ff @(posedge array_clk or posedge reset) begin
        if (reset) begin
            out_word <= '0;
        end else if (load_word) begin
            out_word <= {unit_id, cap_s, cap_q, cap_len};
        end
    end

    // Saturating count of words accepted downstream.
    always_ff @(posedge array_clk or posedge reset) begin
        if (reset) begin
            hit_count <= '0;
        end else if (accept && (hit_count != {CNT_W{1'b1}})) begin
            hit_count <= hit_count + 1'b1;
        end
    end

`ifdef HIT_LEN_FILTER_EN
    // Saturating count of hits discarded by the length filter.
    always_ff @(posedge array_clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (count_drop && (drop_count != {CNT_W{1'b1}})) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_hit_fifo_drain.sv
// Testbench for hit_fifo_drain: a queue-backed FIFO model answers read_HSP,
// a scoreboard holds the words each pushed entry should produce, and a
// negedge monitor pops and compares every accepted word.
module tb_hit_fifo_drain;

    localparam int LC      = 8;
    localparam int CW      = 16;
    localparam int MIN_LEN = 4;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] s;
        logic [7:0] len;
    } entry_t;

    logic        array_clk;
    logic        reset;
    logic [7:0]  unit_id;
    logic [15:0] hit_count;
    logic [15:0] drop_count;
    logic        busy;

    hit_fifo_drain_if #(.LENGTH_COUNTER(LC)) bus();

    hit_fifo_drain #(
        .LENGTH_COUNTER(LC),
        .READ_LATENCY  (1),
        .CNT_W         (CW),
        .MIN_LEN       (MIN_LEN)
    ) dut (
        .array_clk (array_clk),
        .reset     (reset),
        .unit_id   (unit_id),
        .bus       (bus),
        .hit_count (hit_count),
        .drop_count(drop_count),
        .busy      (busy)
    );

    entry_t      fifo_q[$];
    logic [31:0] sb[$];
    entry_t      popped;
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    int          exp_hits = 0;
    int          exp_drops = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_data = '0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_keeps(input logic [7:0] len);
        if (len == 8'h00) return 1'b0;
`ifdef HIT_LEN_FILTER_EN
        if (len < 8'(MIN_LEN)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Push one FIFO entry and record what the DUT should do with it.
    task automatic applyStimulus(input logic [7:0] q, input logic [7:0] s, input logic [7:0] len);
        entry_t e;
        @(posedge array_clk);
        #1;
        e.q   = q;
        e.s   = s;
        e.len = len;
        fifo_q.push_back(e);
        if (model_keeps(len)) begin
            sb.push_back({unit_id, s, q, len});
            exp_hits++;
        end else if (len != 8'h00) begin
            exp_drops++;
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge array_clk);
            #1;
            if (fifo_q.size() == 0 && sb.size() == 0 && bus.fifo_empty && !busy) done = 1'b1;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge array_clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        array_clk = 1'b0;
        forever #5 array_clk = ~array_clk;
    end

    // FIFO model: one-cycle read latency, data appears just after the pop edge.
    initial begin
        bus.fifo_empty        = 1'b1;
        bus.hit_add_inQ_UnGap = '0;
        bus.hit_add_inS_UnGap = '0;
        bus.hit_length_UnGap  = '0;
        forever begin
            @(posedge array_clk);
            if (bus.read_HSP === 1'b1 && reset === 1'b0) begin
                pulses++;
                checkOutput("pop_when_nonempty", 32'(fifo_q.size() != 0), 32'd1);
                checkOutput("pop_while_valid", 32'(bus.out_valid), 32'd0);
                #2;
                if (fifo_q.size() != 0) begin
                    popped = fifo_q.pop_front();
                    bus.hit_add_inQ_UnGap = popped.q;
                    bus.hit_add_inS_UnGap = popped.s;
                    bus.hit_length_UnGap  = popped.len;
                end
            end else begin
                #2;
            end
            bus.fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Output monitor: scoreboard compare on handshake, stability while stalled.
    initial begin
        logic [31:0] exp_word;
        forever begin
            @(negedge array_clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
                    checkOutput("hold_data", bus.out_data, pend_data);
                end
                if (bus.out_valid && bus.out_ready) begin
                    exp_word = (sb.size() != 0) ? sb.pop_front() : ~bus.out_data;
                    checkOutput("out_word", bus.out_data, exp_word);
                end
                pend      = bus.out_valid & ~bus.out_ready;
                pend_data = bus.out_data;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        reset         = 1'b1;
        unit_id       = 8'h00;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge array_clk);
        #1;
        checkOutput("rst_out_data", bus.out_data, 32'h0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b0;

        $display("[TB] idle with empty FIFO");
        p0 = pulses;
        repeat (20) @(posedge array_clk);
        #1;
        checkOutput("t1_pulses", 32'(pulses - p0), 32'd0);
        checkOutput("t1_read_HSP", 32'(bus.read_HSP), 32'd0);
        checkOutput("t1_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t1_hit_count", 32'(hit_count), 32'd0);
        checkOutput("t1_drop_count", 32'(drop_count), 32'd0);
        checkOutput("t1_busy", 32'(busy), 32'd0);

        $display("[TB] single hit");
        unit_id = 8'h02;
        p0 = pulses;
        applyStimulus(8'h41, 8'h17, 8'h09);
        wait_idle("t2_done");
        checkOutput("t2_pulses", 32'(pulses - p0), 32'd1);
        checkOutput("t2_out_data", bus.out_data, 32'h0217_4109);
        checkOutput("t2_hit_count", 32'(hit_count), 32'(exp_hits));

        $display("[TB] bubbles around one hit");
        p0 = pulses;
        applyStimulus(8'h10, 8'h20, 8'h00);
        applyStimulus(8'h11, 8'h21, 8'h05);
        applyStimulus(8'h12, 8'h22, 8'h00);
        wait_idle("t3_done");
        checkOutput("t3_pulses", 32'(pulses - p0), 32'd3);
        checkOutput("t3_out_data", bus.out_data, 32'h0221_1105);
        checkOutput("t3_hit_count", 32'(hit_count), 32'(exp_hits));

        $display("[TB] back-pressure in SEND");
        bus.out_ready = 1'b0;
        p0 = pulses;
        applyStimulus(8'h51, 8'h61, 8'h06);
        applyStimulus(8'h52, 8'h62, 8'h07);
        wait_valid("t4_valid_seen");
        repeat (10) @(posedge array_clk);
        #1;
        checkOutput("t4_stall_pulses", 32'(pulses - p0), 32'd1);
        checkOutput("t4_stall_data", bus.out_data, 32'h0261_5106);
        checkOutput("t4_stall_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        wait_idle("t4_done");
        checkOutput("t4_pulses", 32'(pulses - p0), 32'd2);
        checkOutput("t4_hit_count", 32'(hit_count), 32'(exp_hits));

        $display("[TB] lengths around the filter threshold");
        p0 = pulses;
        applyStimulus(8'h71, 8'h81, 8'h03);
        applyStimulus(8'h72, 8'h82, 8'h04);
        wait_idle("t5_done");
        checkOutput("t5_pulses", 32'(pulses - p0), 32'd2);
        checkOutput("t5_hit_count", 32'(hit_count), 32'(exp_hits));
        checkOutput("t5_drop_count", 32'(drop_count), 32'(exp_drops));

        $display("[TB] reset during SEND");
        bus.out_ready = 1'b0;
        applyStimulus(8'h33, 8'h44, 8'h07);
        wait_valid("t6_valid_seen");
        #3;
        reset = 1'b1;
        #1;
        checkOutput("t6_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_read_HSP", 32'(bus.read_HSP), 32'd0);
        checkOutput("t6_hit_count", 32'(hit_count), 32'd0);
        checkOutput("t6_drop_count", 32'(drop_count), 32'd0);
        checkOutput("t6_out_data", bus.out_data, 32'h0);
        sb.delete();
        exp_hits  = 0;
        exp_drops = 0;
        repeat (2) @(posedge array_clk);
        #1;
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        p0 = pulses;
        applyStimulus(8'h35, 8'h46, 8'h0A);
        wait_idle("t6_resume_done");
        checkOutput("t6_resume_pulses", 32'(pulses - p0), 32'd1);
        checkOutput("t6_resume_hit_count", 32'(hit_count), 32'(exp_hits));
        checkOutput("t6_resume_data", bus.out_data, 32'h0246_350A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
